// File: rtl/opll_pkg.sv
// Shared OPLL constants, the queued write entry type and the register address classifier.
package opll_pkg;

  localparam int unsigned NUM_SLOTS  = 18;
  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned NUM_CH     = 9;
  localparam int unsigned FRAME_SLOT = 17;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SLOT_W  = 5;
  localparam int unsigned STAGE_W = $clog2(NUM_STAGES);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    GLOBAL  = 2'd1,
    CHANNEL = 2'd2
  } addr_class_t;

  // Globals live at 0x00-0x07 and 0x0E; channel registers are 0xR0-0xR8 for R = 1..3.
  function automatic addr_class_t addr_class(input logic [ADDR_W-1:0] addr);
    addr_class_t cls;
    cls = INVALID;
    if (addr[5:4] == 2'b00) begin
      if (!addr[3] || addr[3:0] == 4'hE) cls = GLOBAL;
    end else if (32'(addr[3:0]) < NUM_CH) begin
      cls = CHANNEL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/opll_reg_write_scheduler_if.sv
// CPU write port and register-file write port of the OPLL register write scheduler.
interface opll_reg_write_scheduler_if;
  import opll_pkg::*;

  logic              cpu_wr;
  logic              cpu_a;
  logic [DATA_W-1:0] cpu_d;
  logic              cpu_busy;
  logic              overflow;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_data;

  modport master (
    output cpu_wr, cpu_a, cpu_d,
    input  cpu_busy, overflow, reg_we, reg_addr, reg_data
  );

  modport slave (
    input  cpu_wr, cpu_a, cpu_d,
    output cpu_busy, overflow, reg_we, reg_addr, reg_data
  );

endinterface

// File: rtl/opll_wr_fifo.sv
// Synchronous write queue; pointers carry one extra wrap bit so full and empty are distinct.
module opll_wr_fifo
  import opll_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wr_entry_t        wr_entry,
  output wr_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);

  wr_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (32'(count) == DEPTH);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[PTR_W-2:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[PTR_W-2:0]] <= wr_entry;
        wr_ptr                 <= wr_ptr + PTR_W'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/opll_reg_write_scheduler.sv
// Queues CPU register writes and commits them only where the OPLL core is not reading that register.
module opll_reg_write_scheduler
  import opll_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned COMMIT_STAGE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clkena,
  input  logic [SLOT_W-1:0]  slot,
  input  logic [STAGE_W-1:0] stage,
  opll_reg_write_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_valid;

  wr_entry_t         wr_entry_c;
  wr_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PTR_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  count_next_c;

  addr_class_t       head_class_c;
  logic              enq_req_c;
  logic              push_c;
  logic              drop_full_c;
  logic              head_ok_c;
  logic              commit_c;

  opll_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_c),
    .pop      (commit_c),
    .wr_entry (wr_entry_c),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // A full queue refuses the write even when a commit frees a slot on the same edge.
  always_comb begin
    enq_req_c       = bus.cpu_wr & bus.cpu_a & lat_valid & (addr_class(lat_addr) != INVALID);
    push_c          = enq_req_c & ~fifo_full;
    drop_full_c     = enq_req_c & fifo_full;
    wr_entry_c.addr = lat_addr;
    wr_entry_c.data = bus.cpu_d;

    head_class_c = addr_class(head.addr);
    head_ok_c    = 1'b0;
    case (head_class_c)
      GLOBAL:  head_ok_c = (slot == SLOT_W'(FRAME_SLOT));
      CHANNEL: head_ok_c = (32'(slot) < NUM_SLOTS) && (slot[SLOT_W-1:1] != head.addr[3:0]);
      default: head_ok_c = 1'b0;
    endcase

    commit_c     = clkena & (stage == STAGE_W'(COMMIT_STAGE)) & ~fifo_empty & head_ok_c;
    count_next_c = fifo_count + PTR_W'(push_c) - PTR_W'(commit_c);
  end

  // Address latch, sticky overflow and the registered register-file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr     <= '0;
      lat_valid    <= 1'b1;
      bus.overflow <= 1'b0;
      bus.cpu_busy <= 1'b0;
      bus.reg_we   <= 1'b0;
      bus.reg_addr <= '0;
      bus.reg_data <= '0;
    end else begin
      if (bus.cpu_wr && !bus.cpu_a) begin
        lat_addr  <= bus.cpu_d[ADDR_W-1:0];
        lat_valid <= (bus.cpu_d[DATA_W-1:ADDR_W] == 2'b00);
      end
      if (drop_full_c) bus.overflow <= 1'b1;
      bus.cpu_busy <= (32'(count_next_c) == FIFO_DEPTH);
      bus.reg_we   <= commit_c;
      if (commit_c) begin
        bus.reg_addr <= head.addr;
        bus.reg_data <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_opll_reg_write_scheduler.sv
// Directed and random checks of the OPLL write scheduler against a queue-based reference model.
module tb_opll_reg_write_scheduler;

  localparam int DEPTH        = 4;
  localparam int COMMIT_STAGE = 3;

  logic       clk;
  logic       reset;
  logic       clkena;
  logic [4:0] slot;
  logic [1:0] stage;

  opll_reg_write_scheduler_if bus();

  opll_reg_write_scheduler #(
    .FIFO_DEPTH   (DEPTH),
    .COMMIT_STAGE (COMMIT_STAGE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clkena (clkena),
    .slot   (slot),
    .stage  (stage),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [5:0] qa[$];
  logic [7:0] qd[$];
  logic [5:0] m_lat;
  bit         m_lat_valid;
  bit         m_ovf;
  logic       exp_we;
  logic [5:0] exp_addr;
  logic [7:0] exp_data;
  int         last_slot;
  int         last_stage;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_global(input logic [5:0] a);
    return (int'(a) <= 7) || (int'(a) == 14);
  endfunction

  function automatic bit m_is_channel(input logic [5:0] a);
    return (int'(a) >= 16) && (int'(a) <= 56) && ((int'(a) % 16) <= 8);
  endfunction

  function automatic bit m_eligible(input logic [5:0] a, input int s);
    int ch;
    if (m_is_global(a)) return (s == 17);
    ch = int'(a) % 16;
    return (s < 18) && (s != 2 * ch) && (s != 2 * ch + 1);
  endfunction

  task automatic advance();
    if (int'(stage) == 3) begin
      stage = 2'd0;
      if (int'(slot) < 17) slot = slot + 5'd1;
      else if (int'(slot) == 17) slot = 5'd0;
    end else begin
      stage = stage + 2'd1;
    end
  endtask

  task automatic check_outputs();
    check("reg_we", 32'(bus.reg_we), 32'(exp_we));
    check("reg_addr", 32'(bus.reg_addr), 32'(exp_addr));
    check("reg_data", 32'(bus.reg_data), 32'(exp_data));
    check("cpu_busy", 32'(bus.cpu_busy), 32'(qa.size() == DEPTH));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic wr, input logic a, input logic [7:0] d, input logic ena);
    bit do_commit;
    bit do_push;
    bit do_ovf;
    bus.cpu_wr = wr;
    bus.cpu_a  = a;
    bus.cpu_d  = d;
    clkena     = ena;
    last_slot  = int'(slot);
    last_stage = int'(stage);
    do_commit  = 1'b0;
    do_push    = 1'b0;
    do_ovf     = 1'b0;
    if (ena && int'(stage) == COMMIT_STAGE && qa.size() > 0) begin
      if (m_eligible(qa[0], int'(slot))) do_commit = 1'b1;
    end
    if (wr && a && m_lat_valid && (m_is_global(m_lat) || m_is_channel(m_lat))) begin
      if (qa.size() == DEPTH) do_ovf = 1'b1;
      else do_push = 1'b1;
    end
    @(posedge clk);
    #1;
    if (do_commit) begin
      exp_addr = qa.pop_front();
      exp_data = qd.pop_front();
    end
    exp_we = do_commit;
    if (do_push) begin
      qa.push_back(m_lat);
      qd.push_back(d);
    end
    if (do_ovf) m_ovf = 1'b1;
    if (wr && !a) begin
      m_lat       = d[5:0];
      m_lat_valid = (d[7:6] == 2'b00);
    end
    if (ena) advance();
    bus.cpu_wr = 1'b0;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.cpu_wr = 1'b0;
    bus.cpu_a  = 1'b0;
    bus.cpu_d  = 8'h00;
    clkena     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    qa.delete();
    qd.delete();
    m_lat       = 6'h00;
    m_lat_valid = 1'b1;
    m_ovf       = 1'b0;
    exp_we      = 1'b0;
    exp_addr    = 6'h00;
    exp_data    = 8'h00;
    slot        = 5'd0;
    stage       = 2'd0;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic run_to(input int s, input int st);
    for (int i = 0; i < 80 && !(int'(slot) == s && int'(stage) == st); i++) step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic wait_commit(input int max_steps, input logic ena, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_steps && !found; i++) begin
      step(1'b0, 1'b0, 8'h00, ena);
      if (bus.reg_we === 1'b1) found = 1'b1;
    end
  endtask

  task automatic expect_commit(input string tag, input int s, input logic [5:0] a, input logic [7:0] d);
    bit found;
    wait_commit(200, 1'b1, found);
    check({tag, "_found"}, 32'(found), 32'd1);
    check({tag, "_slot"}, 32'(last_slot), 32'(s));
    check({tag, "_stage"}, 32'(last_stage), 32'(COMMIT_STAGE));
    check({tag, "_addr"}, 32'(bus.reg_addr), 32'(a));
    check({tag, "_data"}, 32'(bus.reg_data), 32'(d));
  endtask

  task automatic expect_no_commit(input string tag, input int n, input logic ena);
    bit found;
    wait_commit(n, ena, found);
    check({tag, "_none"}, 32'(found), 32'd0);
  endtask

  initial begin
    int r;
    logic e;
    reset      = 1'b1;
    clkena     = 1'b0;
    slot       = 5'd0;
    stage      = 2'd0;
    bus.cpu_wr = 1'b0;
    bus.cpu_a  = 1'b0;
    bus.cpu_d  = 8'h00;
    @(negedge clk);
    do_reset();
    check("rst_reg_we", 32'(bus.reg_we), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);

    // Channel 0 write in slot 5 commits at stage 3 of the same slot, one pulse.
    run_to(4, 3);
    step(1'b1, 1'b0, 8'h10, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    expect_commit("t1", 5, 6'h10, 8'h55);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t1_single_pulse", 32'(bus.reg_we), 32'd0);
    check("t1_addr_hold", 32'(bus.reg_addr), 32'h10);

    // Channel 2 is blocked through slots 4 and 5.
    run_to(3, 3);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b1, 8'h66, 1'b1);
    expect_commit("t2", 6, 6'h22, 8'h66);

    // Global register waits for the frame boundary.
    run_to(17, 3);
    step(1'b1, 1'b0, 8'h0E, 1'b1);
    step(1'b1, 1'b1, 8'h20, 1'b1);
    expect_commit("t3", 17, 6'h0E, 8'h20);

    // Blocked channel-2 head keeps the channel-5 write behind it.
    run_to(4, 0);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b1, 8'hA1, 1'b1);
    step(1'b1, 1'b0, 8'h25, 1'b1);
    step(1'b1, 1'b1, 8'hA2, 1'b1);
    expect_commit("t4a", 6, 6'h22, 8'hA1);
    expect_commit("t4b", 7, 6'h25, 8'hA2);

    // Fill behind a global head, overflow on the fifth write, then four ordered commits.
    run_to(0, 0);
    step(1'b1, 1'b0, 8'h02, 1'b1);
    step(1'b1, 1'b1, 8'h01, 1'b1);
    step(1'b1, 1'b0, 8'h13, 1'b1);
    step(1'b1, 1'b1, 8'h02, 1'b1);
    step(1'b1, 1'b1, 8'h03, 1'b1);
    check("t5_not_busy_at_3", 32'(bus.cpu_busy), 32'd0);
    step(1'b1, 1'b1, 8'h04, 1'b1);
    check("t5_busy_at_4", 32'(bus.cpu_busy), 32'd1);
    step(1'b1, 1'b1, 8'h05, 1'b1);
    check("t5_overflow", 32'(bus.overflow), 32'd1);
    expect_commit("t5a", 17, 6'h02, 8'h01);
    expect_commit("t5b", 0, 6'h13, 8'h02);
    expect_commit("t5c", 1, 6'h13, 8'h03);
    expect_commit("t5d", 2, 6'h13, 8'h04);
    expect_no_commit("t5e", 40, 1'b1);
    check("t5_overflow_sticky", 32'(bus.overflow), 32'd1);

    // Reset discards three queued globals.
    run_to(1, 0);
    step(1'b1, 1'b0, 8'h05, 1'b1);
    step(1'b1, 1'b1, 8'hB1, 1'b1);
    step(1'b1, 1'b1, 8'hB2, 1'b1);
    step(1'b1, 1'b1, 8'hB3, 1'b1);
    do_reset();
    check("t8_busy", 32'(bus.cpu_busy), 32'd0);
    check("t8_overflow", 32'(bus.overflow), 32'd0);
    expect_no_commit("t8", 80, 1'b1);

    // Invalid addresses and an invalid latch are dropped silently.
    step(1'b1, 1'b0, 8'h19, 1'b1);
    step(1'b1, 1'b1, 8'h01, 1'b1);
    step(1'b1, 1'b0, 8'h3F, 1'b1);
    step(1'b1, 1'b1, 8'h02, 1'b1);
    step(1'b1, 1'b0, 8'h0A, 1'b1);
    step(1'b1, 1'b1, 8'h03, 1'b1);
    step(1'b1, 1'b0, 8'hC0, 1'b1);
    step(1'b1, 1'b1, 8'h04, 1'b1);
    expect_no_commit("t6", 80, 1'b1);
    check("t6_overflow", 32'(bus.overflow), 32'd0);

    // clkena low: writes are queued, nothing commits until clkena returns.
    run_to(0, 3);
    step(1'b1, 1'b0, 8'h15, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    expect_no_commit("t9", 10, 1'b0);
    expect_commit("t9", 0, 6'h15, 8'h77);

    // Out-of-range slot numbers never commit.
    slot  = 5'd20;
    stage = 2'd0;
    step(1'b1, 1'b0, 8'h10, 1'b1);
    step(1'b1, 1'b1, 8'h99, 1'b1);
    expect_no_commit("t10", 12, 1'b1);
    slot  = 5'd5;
    stage = 2'd0;
    expect_commit("t10", 5, 6'h10, 8'h99);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      e = ($urandom_range(0, 9) < 8);
      if (r < 1) do_reset();
      else if (r < 15)
        step(1'b1, 1'b0, {(($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00), 6'($urandom_range(0, 63))}, e);
      else if (r < 45) step(1'b1, 1'b1, 8'($urandom), e);
      else step(1'b0, 1'b0, 8'h00, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
